// File: rtl/opl3_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// opl3_pkg: shared types for the OPL3 register-write path.
// Revision: 1.0
// -----------------------------------------------------------------------------
package opl3_pkg;

  localparam int REG_FILE_DATA_WIDTH = 8;
  localparam int REG_ADDR_WIDTH      = 8;

  typedef struct packed {
    logic                           valid;
    logic                           bank;
    logic [REG_ADDR_WIDTH-1:0]      address;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
  } reg_wr_t;

  localparam int REG_WR_WIDTH = $bits(reg_wr_t);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_GAP  = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    GRANT_HOST   = 1'b0,
    GRANT_LOADER = 1'b1
  } grant_src_e;

endpackage
`default_nettype wire

// File: rtl/reg_wr_fifo.sv
`default_nettype none
// -----------------------------------------------------------------------------
// reg_wr_fifo: first-word-fall-through FIFO; a new entry is presented to the
// reader one cycle after it is written. Revision: 1.0
// -----------------------------------------------------------------------------
module reg_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             pending_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      wr_vis_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Reader sees the write pointer one cycle late, giving the two-edge host latency.
  assign empty_o   = (wr_vis_q == rd_ptr_q);
  assign pending_o = (wr_ptr_q != rd_ptr_q);
  assign pop_ok    = pop_i && !empty_o;
  assign push_ok   = push_i && (!full_o || pop_ok);
  assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      wr_vis_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_vis_q <= wr_ptr_q;
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/opl3_reg_wr_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// opl3_reg_wr_arbiter: round-robin merge of host and loader register writes
// with a minimum gap between issued writes. Revision: 1.0
// -----------------------------------------------------------------------------
module opl3_reg_wr_arbiter
  import opl3_pkg::*;
#(
  parameter int HOST_FIFO_DEPTH = 8,
  parameter int MIN_GAP         = 3
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [REG_WR_WIDTH-1:0]        host_reg_wr,
  input  logic                           ldr_valid,
  input  logic                           ldr_bank,
  input  logic [REG_ADDR_WIDTH-1:0]      ldr_address,
  input  logic [REG_FILE_DATA_WIDTH-1:0] ldr_data,
  output logic                           ldr_ready,
  input  logic                           pause,
  output logic [REG_WR_WIDTH-1:0]        opl3_reg_wr,
  output logic                           busy,
  output logic                           host_overflow
);

  localparam int GAP_W   = ($clog2(MIN_GAP + 1) < 1) ? 1 : $clog2(MIN_GAP + 1);
  localparam bit HAS_GAP = (MIN_GAP > 0);
  localparam logic [GAP_W-1:0] GAP_RELOAD = HAS_GAP ? GAP_W'(MIN_GAP - 1) : '0;

  arb_state_e                state_q, state_d;
  logic [GAP_W-1:0]          gap_cnt_q, gap_cnt_d;
  grant_src_e                last_grant_q, last_grant_d;
  reg_wr_t                   out_q, out_d;
  logic                      overflow_q, overflow_d;

  logic                      grant_vld;
  grant_src_e                grant_src;
  logic                      host_pop;
  logic                      fifo_full, fifo_empty, fifo_pending;
  logic [REG_WR_WIDTH-2:0]   fifo_rdata;

  reg_wr_fifo #(
    .DEPTH (HOST_FIFO_DEPTH),
    .WIDTH (REG_WR_WIDTH - 1)
  ) u_host_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push_i    (host_reg_wr[REG_WR_WIDTH-1]),
    .pop_i     (host_pop),
    .wdata_i   (host_reg_wr[REG_WR_WIDTH-2:0]),
    .rdata_o   (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .pending_o (fifo_pending)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      gap_cnt_q    <= '0;
      last_grant_q <= GRANT_LOADER;
      out_q        <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      out_q        <= out_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    out_d        = out_q;
    out_d.valid  = 1'b0;
    overflow_d   = overflow_q |
                   (host_reg_wr[REG_WR_WIDTH-1] & fifo_full & ~host_pop);
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          last_grant_d = grant_src;
          out_d.valid  = 1'b1;
          {out_d.bank, out_d.address, out_d.data} =
            (grant_src == GRANT_HOST) ? fifo_rdata : {ldr_bank, ldr_address, ldr_data};
          if (HAS_GAP) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_RELOAD;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == '0) state_d = ST_IDLE;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant_vld = 1'b0;
    grant_src = last_grant_q;
    if (state_q == ST_IDLE && !pause) begin
      if (!fifo_empty && ldr_valid) begin
        grant_vld = 1'b1;
        grant_src = (last_grant_q == GRANT_HOST) ? GRANT_LOADER : GRANT_HOST;
      end else if (!fifo_empty) begin
        grant_vld = 1'b1;
        grant_src = GRANT_HOST;
      end else if (ldr_valid) begin
        grant_vld = 1'b1;
        grant_src = GRANT_LOADER;
      end
    end
  end

  assign host_pop      = grant_vld && (grant_src == GRANT_HOST);
  assign ldr_ready     = grant_vld && (grant_src == GRANT_LOADER);
  assign opl3_reg_wr   = out_q;
  assign host_overflow = overflow_q;
  assign busy          = fifo_pending | ldr_valid | (state_q == ST_GAP) | out_q.valid;

endmodule
`default_nettype wire

// File: tb/tb_opl3_reg_wr_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_opl3_reg_wr_arbiter: scoreboard bench for the register-write arbiter.
// Revision: 1.0
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_opl3_reg_wr_arbiter;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [17:0] host_reg_wr = '0;
  logic        ldr_valid = 1'b0, ldr_bank = 1'b0;
  logic [7:0]  ldr_address = '0, ldr_data = '0;
  logic        ldr_ready, busy, host_overflow;
  logic        pause = 1'b0;
  logic [17:0] opl3_reg_wr;

  logic [17:0] g0_host_reg_wr = '0;
  logic        g0_ldr_valid = 1'b0, g0_ldr_bank = 1'b0;
  logic [7:0]  g0_ldr_address = '0, g0_ldr_data = '0;
  logic        g0_ldr_ready, g0_busy, g0_host_overflow;
  logic        g0_pause = 1'b0;
  logic [17:0] g0_opl3_reg_wr;

  int          n_checks = 0;
  int          n_pass = 0;
  int          edge_n = 0;
  logic [17:0] got_q[$];
  int          got_e[$];
  logic [17:0] got0_q[$];
  int          got0_e[$];
  logic [17:0] exp_q[$];
  int          exp_e[$];

  opl3_reg_wr_arbiter #(.HOST_FIFO_DEPTH(DEPTH), .MIN_GAP(3)) u_dut (
    .clk(clk), .reset_n(reset_n), .host_reg_wr(host_reg_wr),
    .ldr_valid(ldr_valid), .ldr_bank(ldr_bank), .ldr_address(ldr_address),
    .ldr_data(ldr_data), .ldr_ready(ldr_ready), .pause(pause),
    .opl3_reg_wr(opl3_reg_wr), .busy(busy), .host_overflow(host_overflow)
  );

  opl3_reg_wr_arbiter #(.HOST_FIFO_DEPTH(DEPTH), .MIN_GAP(0)) u_dut_g0 (
    .clk(clk), .reset_n(reset_n), .host_reg_wr(g0_host_reg_wr),
    .ldr_valid(g0_ldr_valid), .ldr_bank(g0_ldr_bank), .ldr_address(g0_ldr_address),
    .ldr_data(g0_ldr_data), .ldr_ready(g0_ldr_ready), .pause(g0_pause),
    .opl3_reg_wr(g0_opl3_reg_wr), .busy(g0_busy), .host_overflow(g0_host_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (opl3_reg_wr[17]) begin
      got_q.push_back(opl3_reg_wr);
      got_e.push_back(edge_n);
    end
    if (g0_opl3_reg_wr[17]) begin
      got0_q.push_back(g0_opl3_reg_wr);
      got0_e.push_back(edge_n);
    end
  end

  task automatic apply_reset();
    host_reg_wr = '0; ldr_valid = 1'b0; pause = 1'b0; g0_ldr_valid = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    got_q.delete(); got_e.delete(); got0_q.delete(); got0_e.delete();
    exp_q.delete(); exp_e.delete();
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (opl3_reg_wr !== 18'h0 || ldr_ready !== 1'b0 || busy !== 1'b0 || host_overflow !== 1'b0)
      $display("FAIL reset_outputs got wr=%h rdy=%b busy=%b ovf=%b want all 0",
               opl3_reg_wr, ldr_ready, busy, host_overflow);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_single_host();
    int e0;
    logic [17:0] gv, ev;
    int ge, ee;
    apply_reset();
    e0 = edge_n + 1;
    exp_q.push_back(18'h30501); exp_e.push_back(e0 + 2);
    host_reg_wr = 18'h30501;
    @(posedge clk); #1 host_reg_wr = '0;
    repeat (8) @(posedge clk); #1;
    n_checks++;
    if (got_q.size() != 1) $display("FAIL single_count got %0d want 1", got_q.size());
    else n_pass++;
    while (exp_q.size() != 0) begin
      ev = exp_q.pop_front(); ee = exp_e.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL single_missing got none want %h", ev);
      else begin
        gv = got_q.pop_front(); ge = got_e.pop_front();
        if (gv !== ev || ge != ee) $display("FAIL single_write got %h@%0d want %h@%0d", gv, ge, ev, ee);
        else n_pass++;
      end
    end
    n_checks++;
    if (opl3_reg_wr !== 18'h10501 || busy !== 1'b0)
      $display("FAIL single_hold got wr=%h busy=%b want 10501/0", opl3_reg_wr, busy);
    else n_pass++;
  endtask

  task automatic test_tie();
    int e0, ee, ge;
    logic seen;
    logic [17:0] gv, ev;
    apply_reset();
    e0 = edge_n + 1;
    host_reg_wr = 18'h2A044;
    @(posedge clk); #1 host_reg_wr = '0;
    @(posedge clk); #1;
    ldr_valid = 1'b1; ldr_bank = 1'b1; ldr_address = 8'hB0; ldr_data = 8'h20;
    exp_q.push_back(18'h2A044); exp_e.push_back(e0 + 2);
    exp_q.push_back(18'h3B020); exp_e.push_back(e0 + 6);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      if (ldr_ready) seen = 1'b1;
    end
    n_checks++;
    if (!seen || edge_n != e0 + 5)
      $display("FAIL tie_ldr_ready got seen=%b edge=%0d want 1 edge=%0d", seen, edge_n, e0 + 5);
    else n_pass++;
    @(posedge clk); #1 ldr_valid = 1'b0;
    repeat (6) @(posedge clk); #1;
    while (exp_q.size() != 0) begin
      ev = exp_q.pop_front(); ee = exp_e.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL tie_missing got none want %h", ev);
      else begin
        gv = got_q.pop_front(); ge = got_e.pop_front();
        if (gv !== ev || ge != ee) $display("FAIL tie_order got %h@%0d want %h@%0d", gv, ge, ev, ee);
        else n_pass++;
      end
    end
    n_checks++;
    if (got_q.size() != 0 || busy !== 1'b0)
      $display("FAIL tie_extra got extra=%0d busy=%b want 0/0", got_q.size(), busy);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int e0, occ, nacc, ee, ge;
    logic pop;
    logic [17:0] wr, gv, ev;
    apply_reset();
    e0 = edge_n + 1;
    occ = 0; nacc = 0;
    for (int k = 0; k < 12; k++) begin
      wr = {1'b1, k[0], 8'(8'h10 + k), 8'(k * 3)};
      host_reg_wr = wr;
      // Uncontested host issues land every 4 edges starting 2 after the first push.
      pop = (k >= 2) && ((k - 2) % 4 == 0);
      if (occ < DEPTH || pop) begin
        exp_q.push_back(wr); exp_e.push_back(e0 + 2 + 4 * nacc);
        nacc++; occ++;
      end
      if (pop) occ--;
      @(posedge clk); #1;
      if (k == 10) begin
        n_checks++;
        if (host_overflow !== 1'b0) $display("FAIL ovf_early got %b want 0", host_overflow);
        else n_pass++;
      end
    end
    host_reg_wr = '0;
    n_checks++;
    if (host_overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", host_overflow);
    else n_pass++;
    repeat (48) @(posedge clk); #1;
    while (exp_q.size() != 0) begin
      ev = exp_q.pop_front(); ee = exp_e.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL ovf_missing got none want %h", ev);
      else begin
        gv = got_q.pop_front(); ge = got_e.pop_front();
        if (gv !== ev || ge != ee) $display("FAIL ovf_order got %h@%0d want %h@%0d", gv, ge, ev, ee);
        else n_pass++;
      end
    end
    n_checks++;
    if (got_q.size() != 0 || host_overflow !== 1'b1)
      $display("FAIL ovf_extra got extra=%0d ovf=%b want 0/1", got_q.size(), host_overflow);
    else n_pass++;
  endtask

  task automatic test_reset_mid_gap();
    int e0, ee, ge;
    logic [17:0] gv, ev;
    n_checks++;
    if (host_overflow !== 1'b1) $display("FAIL rst_pre_ovf got %b want 1", host_overflow);
    else n_pass++;
    e0 = edge_n + 1;
    for (int k = 0; k < 3; k++) begin
      host_reg_wr = {2'b10, 8'(8'h40 + k), 8'h5A};
      @(posedge clk); #1;
    end
    host_reg_wr = '0;
    exp_q.push_back({2'b10, 8'h40, 8'h5A}); exp_e.push_back(e0 + 2);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (opl3_reg_wr !== 18'h0 || busy !== 1'b0 || host_overflow !== 1'b0 || ldr_ready !== 1'b0)
      $display("FAIL rst_async got wr=%h busy=%b ovf=%b rdy=%b want all 0",
               opl3_reg_wr, busy, host_overflow, ldr_ready);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(posedge clk); #1;
    while (exp_q.size() != 0) begin
      ev = exp_q.pop_front(); ee = exp_e.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL rst_missing got none want %h", ev);
      else begin
        gv = got_q.pop_front(); ge = got_e.pop_front();
        if (gv !== ev || ge != ee) $display("FAIL rst_first got %h@%0d want %h@%0d", gv, ge, ev, ee);
        else n_pass++;
      end
    end
    n_checks++;
    if (got_q.size() != 0 || host_overflow !== 1'b0 || busy !== 1'b0)
      $display("FAIL rst_stale got extra=%0d ovf=%b busy=%b want 0/0/0", got_q.size(), host_overflow, busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int e0, ee, ge;
    logic [17:0] gv, ev;
    apply_reset();
    e0 = edge_n + 1;
    for (int i = 0; i < 5; i++) begin
      g0_ldr_valid = 1'b1; g0_ldr_bank = i[0];
      g0_ldr_address = 8'(8'h60 + i); g0_ldr_data = 8'(i * 17);
      exp_q.push_back({1'b1, g0_ldr_bank, g0_ldr_address, g0_ldr_data});
      exp_e.push_back(e0 + i);
      @(negedge clk);
      n_checks++;
      if (g0_ldr_ready !== 1'b1) $display("FAIL b2b_ready[%0d] got %b want 1", i, g0_ldr_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    g0_ldr_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    while (exp_q.size() != 0) begin
      ev = exp_q.pop_front(); ee = exp_e.pop_front();
      n_checks++;
      if (got0_q.size() == 0) $display("FAIL b2b_missing got none want %h", ev);
      else begin
        gv = got0_q.pop_front(); ge = got0_e.pop_front();
        if (gv !== ev || ge != ee) $display("FAIL b2b_write got %h@%0d want %h@%0d", gv, ge, ev, ee);
        else n_pass++;
      end
    end
    n_checks++;
    if (got0_q.size() != 0 || g0_busy !== 1'b0)
      $display("FAIL b2b_extra got extra=%0d busy=%b want 0/0", got0_q.size(), g0_busy);
    else n_pass++;
  endtask

  task automatic test_pause();
    int p, ee, ge;
    logic [17:0] wr, gv, ev;
    apply_reset();
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr = {2'b11, 8'(8'h20 + k), 8'(8'hC0 + k)};
      host_reg_wr = wr;
      exp_q.push_back(wr);
      @(posedge clk); #1;
    end
    host_reg_wr = '0;
    repeat (6) @(posedge clk); #1;
    n_checks++;
    if (got_q.size() != 0 || busy !== 1'b1)
      $display("FAIL pause_hold got writes=%0d busy=%b want 0/1", got_q.size(), busy);
    else n_pass++;
    p = edge_n;
    pause = 1'b0;
    for (int j = 0; j < 3; j++) exp_e.push_back(p + 1 + 4 * j);
    repeat (11) @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL pause_busy_gap got %b want 1", busy);
    else n_pass++;
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL pause_busy_done got %b want 0", busy);
    else n_pass++;
    while (exp_q.size() != 0) begin
      ev = exp_q.pop_front(); ee = exp_e.pop_front();
      n_checks++;
      if (got_q.size() == 0) $display("FAIL pause_missing got none want %h", ev);
      else begin
        gv = got_q.pop_front(); ge = got_e.pop_front();
        if (gv !== ev || ge != ee) $display("FAIL pause_write got %h@%0d want %h@%0d", gv, ge, ev, ee);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_host();
    test_tie();
    test_overflow();
    test_reset_mid_gap();
    test_back_to_back();
    test_pause();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
